// File: rtl/lcd_display_frame_reader.sv
// Streams one frame of 32-bit words from on-chip memory to an Avalon-ST sink.
// Reads are throttled so the small first-word-fall-through buffer can never overflow.
module lcd_display_frame_reader #(
  parameter int BASE_WORD  = 0,
  parameter int NUM_WORDS  = 40960,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_address,
  output logic        mem_chipselect,
  input  logic [31:0] mem_readdata,
  output logic [31:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_sop,
  output logic        st_eop
);
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      fifo_mem [FIFO_DEPTH];

  logic        issue, pop, store, unload, last_pop, have_word;
  logic [31:0] head;

  always_comb begin
    // The word arriving from memory this cycle counts as occupancy, so it can
    // be presented (and even consumed) without first landing in storage.
    have_word = (count_q != '0) || inflight_q;
    head      = (count_q != '0) ? fifo_mem[rd_ptr_q] : mem_readdata;
    issue     = (state_q == S_FETCH) &&
                ((32'(count_q) + 32'(inflight_q) + 32'd1) <= 32'(FIFO_DEPTH));
    pop       = have_word && st_ready;
    store     = inflight_q && !((count_q == '0) && pop);
    unload    = pop && (count_q != '0);
    last_pop  = pop && (pop_cnt_q == LAST);

    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    pop_cnt_d  = pop_cnt_q;
    inflight_d = issue;
    done_d     = 1'b0;
    wr_ptr_d   = store  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = unload ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(store) - CW'(unload);

    if (pop) begin
      pop_cnt_d = last_pop ? '0 : pop_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          rd_idx_d  = '0;
          pop_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (rd_idx_q == LAST) begin
            state_d  = S_DRAIN;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      fifo_mem[wr_ptr_q] <= mem_readdata;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign mem_chipselect = issue;
  assign mem_address    = 16'(BASE_WORD) + 16'(rd_idx_q);
  assign st_valid       = have_word;
  assign st_data        = have_word ? head : 32'd0;
  assign st_sop         = have_word && (pop_cnt_q == '0);
  assign st_eop         = have_word && (pop_cnt_q == LAST);

endmodule

// File: doc/lcd_display_frame_reader.md
LCD_DISPLAY_FRAME_READER -- requirements
Module: lcd_display_frame_reader

Interface
REQ-001 Parameter BASE_WORD, default 0, first 32-bit word address of the frame in on-chip memory.
REQ-002 Parameter NUM_WORDS, default 40960, frame length in 32-bit words; legal range 1..65536-BASE_WORD.
REQ-003 Parameter FIFO_DEPTH, default 8, output buffer depth in words; power of two, 2..64.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge on clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to stream one frame.
REQ-007 busy  out  1  high from the accepted start until the frame's last word is popped.
REQ-008 done  out  1  one-cycle pulse in the cycle after the last word is popped.
REQ-009 mem_address  out  16  word address to the on-chip memory slave.
REQ-010 mem_chipselect  out  1  read-issue strobe to the memory; write SHALL be tied low outside this block.
REQ-011 mem_readdata  in  32  memory read data; valid exactly 1 cycle after a chipselect cycle.
REQ-012 st_data  out  32  Avalon-ST pixel word.
REQ-013 st_valid  out  1  st_data valid.
REQ-014 st_ready  in  1  downstream accepts when st_valid & st_ready (zero ready latency).
REQ-015 st_sop / st_eop  out  1 each  first / last word of the frame.

Function
REQ-016 States IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after the NUM_WORDS-th read issues; DRAIN->IDLE when the last word is popped.
REQ-017 start in FETCH or DRAIN SHALL be ignored; start in the same cycle as done's IDLE return SHALL be accepted.
REQ-018 Read index i counts 0..NUM_WORDS-1; mem_address = BASE_WORD + i (16-bit, no wrap within legal range).
REQ-019 A read SHALL issue (mem_chipselect=1) in FETCH only when fifo_count + inflight + 1 <= FIFO_DEPTH; inflight is 0 or 1.
REQ-020 First read SHALL issue in the cycle after start is accepted; with st_ready held high, one read per cycle sustained.
REQ-021 mem_readdata SHALL be written into the FIFO in the cycle after its chipselect cycle; the FIFO SHALL never overflow.
REQ-022 FIFO is first-word-fall-through: st_valid = (fifo_count != 0); st_data = head word; first st_valid no earlier than 2 cycles after start.
REQ-023 Pop occurs on st_valid & st_ready; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-024 st_data/st_valid/st_sop/st_eop SHALL hold stable while st_valid & ~st_ready.
REQ-025 st_sop high only with word 0; st_eop high only with word NUM_WORDS-1; NUM_WORDS=1 gives both on one word.
REQ-026 Pop and word counters SHALL be ceil(log2(NUM_WORDS+1)) bits minimum; no arithmetic overflow permitted.
REQ-027 done SHALL be high for exactly one cycle per frame; busy falls in the same cycle done rises.

Reset
REQ-028 On reset: state IDLE, counters and FIFO cleared, inflight cleared; busy=0, done=0, mem_chipselect=0, mem_address=BASE_WORD, st_valid=0, st_sop=0, st_eop=0, st_data=0.
REQ-029 Reset mid-frame SHALL abort: in-flight readdata returning the next cycle is discarded, no done pulse, next start restarts at word 0.

Verification
REQ-030 NUM_WORDS=4, memory word k=0xA000_0000+k, st_ready=1, start at cycle 0 -> reads at cycles 1-4 addr 0-3, st_valid words 0xA0000000..0xA0000003 cycles 2-5, sop cycle 2, eop cycle 5, done cycle 6.
REQ-031 FIFO_DEPTH=4, NUM_WORDS=16, st_ready=0 for 20 cycles -> exactly 4 chipselects then stall, st_data holds word 0; release ready -> all 16 words in order, no loss or duplication.
REQ-032 Random st_ready (50%), NUM_WORDS=1000, BASE_WORD=0x100 -> scoreboard match of 1000 words, one sop, one eop, one done.
REQ-033 start pulsed again during FETCH and DRAIN -> ignored, single frame output; start coincident with done cycle -> second frame begins.
REQ-034 reset asserted at word 7 of 16 with a read in flight -> all outputs at reset values next cycle, no stray st_valid; restart streams words 0-15 correctly.
REQ-035 NUM_WORDS=1 -> single word with st_sop=st_eop=1, done one cycle after pop.
